// File: rtl/osc_tick_pkg.sv
// osc_tick_pkg: shared mode and channel-state encodings and the channel-count limit
// for the oscillator tick generator.
package osc_tick_pkg;
    localparam int MAX_CH = 16;
    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_ONESHOT  = 2'd2
    } mode_e;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_P = 2'd1,
        ST_RUN_1 = 2'd2
    } ch_state_e;
    // Reserved mode 3 falls through to IDLE, same as OFF.
    function automatic ch_state_e state_of(input logic [1:0] mode);
        return mode == MODE_PERIODIC ? ST_RUN_P : mode == MODE_ONESHOT ? ST_RUN_1 : ST_IDLE;
    endfunction
endpackage

// File: rtl/osc_tick_ch.sv
// osc_tick_ch: one tick channel -- run state, down-counter, reload value and
// registered one-cycle TICK pulse.
module osc_tick_ch
    import osc_tick_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    output logic             tick_o,
    output logic             busy_o
);
    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rld_q;
    logic [CNT_W-1:0] rld_d;
    logic             tick_q;

    // max(D,1)-1: subtracting the nonzero flag maps D=0 and D=1 both to 0.
    assign rld_d  = div_i - CNT_W'(div_i != '0);
    assign tick_o = tick_q;
    assign busy_o = state_q != ST_IDLE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (load_i) begin
                rld_q   <= rld_d;
                cnt_q   <= rld_d;
                state_q <= state_of(mode_i);
            end else if (state_q != ST_IDLE && en_i) begin
                if (cnt_q == '0) begin
                    tick_q <= 1'b1;
                    cnt_q  <= rld_q;
                    if (state_q == ST_RUN_1) state_q <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/osc_tick_gen.sv
// osc_tick_gen: configuration handshake, channel decode and out-of-range error
// around NUM_CH independent tick channels.
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [CNT_W-1:0]  CFG_DIV,
    input  logic [1:0]        CFG_MODE,
    input  logic [NUM_CH-1:0] EN,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] BUSY,
    output logic              CFG_ERR
);
    logic ready_q;
    logic err_q;
    logic xfer;

    assign xfer      = CFG_VALID && ready_q;
    assign CFG_READY = ready_q;
    assign CFG_ERR   = err_q;

    // READY drops for the single cycle after any accepted transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= !xfer;
            err_q   <= xfer && 32'(CFG_CH) >= NUM_CH;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        osc_tick_ch #(.CNT_W(CNT_W)) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .load_i (xfer && CFG_CH == CH_W'(i)),
            .div_i  (CFG_DIV),
            .mode_i (CFG_MODE),
            .en_i   (EN[i]),
            .tick_o (TICK[i]),
            .busy_o (BUSY[i])
        );
    end
endmodule

// File: doc/osc_tick_gen.md
OSC_TICK_GEN -- requirements
Module: osc_tick_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 16: divider width in bits (2..32).
REQ-003 Parameter CH_W, default 2: channel select width, equal to the ceiling of log2(NUM_CH) and at least 1.
REQ-004 Port CLK  input  1: single clock, the fabric oscillator clock; all logic is on the rising edge.
REQ-005 Port RST  input  1: synchronous, active-high reset.
REQ-006 Port CFG_VALID  input  1: configuration request.
REQ-007 Port CFG_READY  output  1: configuration can be accepted; a transfer occurs on an edge where CFG_VALID and CFG_READY are both 1.
REQ-008 Port CFG_CH  input  CH_W: target channel.
REQ-009 Port CFG_DIV  input  CNT_W: divide ratio D.
REQ-010 Port CFG_MODE  input  2: 0 = OFF, 1 = PERIODIC, 2 = ONESHOT, 3 = reserved, treated as OFF.
REQ-011 Port EN  input  NUM_CH: per-channel count gate.
REQ-012 Port TICK  output  NUM_CH: per-channel registered one-cycle pulse.
REQ-013 Port BUSY  output  NUM_CH: channel is in PERIODIC or ONESHOT.
REQ-014 Port CFG_ERR  output  1: one-cycle pulse when a transfer addresses a CFG_CH value of NUM_CH or above.

Function
REQ-015 Each channel SHALL hold a state (IDLE, RUN_P, RUN_1), a down-counter of CNT_W bits, and a reload value of CNT_W bits.
REQ-016 On a transfer to channel c, the reload value SHALL be max(D,1)-1; D = 0 behaves as D = 1.
REQ-017 On a transfer to channel c, the counter SHALL be loaded with the reload value.
REQ-018 On a transfer to channel c, the state SHALL become RUN_P for mode 1, RUN_1 for mode 2, and IDLE otherwise.
REQ-019 On the edge after a transfer, CFG_READY SHALL be 0 for exactly one cycle, giving a maximum of one transfer every 2 cycles.
REQ-020 At all other times outside reset, CFG_READY SHALL be 1.
REQ-021 On an edge where the channel is in RUN_P or RUN_1 and EN[c] = 1, a counter value of 0 SHALL set TICK[c] to 1 and reload the counter.
REQ-022 On such an edge, a nonzero counter value SHALL decrement the counter.
REQ-023 On every other edge, TICK[c] SHALL be 0.
REQ-024 Timing: the first TICK SHALL occur D enabled edges after the transfer edge, and subsequent TICKs every D enabled edges.
REQ-025 A RUN_1 channel SHALL go to IDLE on the same edge that asserts its TICK.
REQ-026 EN[c] = 0 SHALL freeze the counter and state and suppress TICK; counting resumes from the held value.
REQ-027 When a transfer to channel c coincides with c's counter reaching 0, the transfer SHALL win: no TICK, and the counter is loaded with the new value.
REQ-028 In IDLE, the counter SHALL hold and no TICK is produced.
REQ-029 A transfer with CFG_CH of NUM_CH or above SHALL pulse CFG_ERR on the next edge, SHALL alter no channel, and SHALL still drop CFG_READY for one cycle.
REQ-030 BUSY[c] SHALL equal 1 when channel c's state is RUN_P or RUN_1.
REQ-031 The counter SHALL never underflow; the wrap from 0 is always a reload.
REQ-032 Channels SHALL be fully independent; simultaneous TICKs on several channels are legal.

Reset
REQ-033 With RST = 1 on an edge, all channels SHALL go to IDLE, counters and reload values SHALL be 0, and TICK, BUSY and CFG_ERR SHALL be 0.
REQ-034 With RST = 1, CFG_READY SHALL be 0; it SHALL become 1 on the first edge with RST = 0.
REQ-035 RST asserted mid-count SHALL abort the count immediately; no TICK is produced on that edge or the following one.
REQ-036 RST SHALL take priority over a concurrent transfer, which is discarded.

Structure
REQ-037 A shared package osc_tick_pkg SHALL define the mode encoding (OFF, PERIODIC, ONESHOT), the channel state enum, and the NUM_CH upper bound constant.
REQ-038 One sub-module osc_tick_ch SHALL implement a single channel (state, counter, reload, TICK register) and SHALL be instantiated NUM_CH times.
REQ-039 The top level SHALL contain only the configuration handshake, channel decode and CFG_ERR logic.

Verification
REQ-040 Periodic: reset, then configure ch0 with D = 5, mode 1, EN = all 1 -> TICK[0] is high 5 edges after the transfer and every 5 edges after that; BUSY[0] = 1; other TICKs stay 0.
REQ-041 Oneshot plus D = 0: configure ch1 with D = 3, mode 2 -> exactly one TICK[1] 3 edges after the transfer, then BUSY[1] = 0. Configure ch2 with D = 0, mode 1 -> TICK[2] is high every cycle.
REQ-042 Gate and collision: ch0 at D = 4; drop EN[0] for 3 cycles mid-count -> the tick is delayed by exactly 3 cycles. Reconfigure ch0 on the edge its counter reaches 0 -> no TICK on that edge; the next tick follows the new D.
REQ-043 Handshake: hold CFG_VALID = 1 for 6 cycles -> exactly 3 transfers, with CFG_READY toggling 1,0,1,0. With NUM_CH = 3, a transfer to CFG_CH = 3 -> one CFG_ERR pulse and no channel change.
REQ-044 Reset mid-operation: with 4 channels running, assert RST for 1 cycle -> all outputs are 0 and CFG_READY = 0 during reset. After reset, no TICK occurs until reconfiguration, and CFG_READY = 1 on the first edge after release.
